// File: rtl/rps_move_capture.sv
// ---------------------------------------------------------------------------
// rps_move_capture
//
// Purpose:
//   Front-end of the rock-paper-scissors game. Captures each player's move
//   secretly from raw push-buttons: every button is synchronised and
//   debounced, each player's selection is held until that player locks in,
//   and once both players are locked the two moves are revealed as one-hot
//   signals with a round_valid strobe that is held until the scoring block
//   accepts it (round_valid && round_ready).
//
// Ports:
//   clk                      system clock, all logic on the rising edge
//   rst                      synchronous active-high reset
//   btn_rock1/paper1/scissors1/lock1   raw asynchronous player-1 buttons
//   btn_rock2/paper2/scissors2/lock2   raw asynchronous player-2 buttons
//   round_ready              scoring block accepts the revealed round
//   rock1/paper1/scissors1   player-1 move, one-hot, only while round_valid
//   rock2/paper2/scissors2   player-2 move, one-hot, only while round_valid
//   round_valid              both moves presented; held until accepted
//   locked1/locked2          player has locked a selection (status LEDs)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples before a level changes
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
// ---------------------------------------------------------------------------
module rps_move_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_rock1,
    input  logic btn_paper1,
    input  logic btn_scissors1,
    input  logic btn_lock1,
    input  logic btn_rock2,
    input  logic btn_paper2,
    input  logic btn_scissors2,
    input  logic btn_lock2,
    input  logic round_ready,
    output logic rock1,
    output logic paper1,
    output logic scissors1,
    output logic rock2,
    output logic paper2,
    output logic scissors2,
    output logic round_valid,
    output logic locked1,
    output logic locked2
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REVEAL  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_NONE     = 2'b00;
    localparam logic [1:0] SEL_ROCK     = 2'b01;
    localparam logic [1:0] SEL_PAPER    = 2'b10;
    localparam logic [1:0] SEL_SCISSORS = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button vector layout per player nibble: {lock, scissors, paper, rock}.
    logic [7:0] btn_raw;
    assign btn_raw = {btn_lock2, btn_scissors2, btn_paper2, btn_rock2,
                      btn_lock1, btn_scissors1, btn_paper1, btn_rock1};

    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       deb_q, deb_d;
    logic [7:0]       deb_prev_q;
    logic [7:0]       press_q;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    state_e     state_q, state_d;
    logic [1:0] sel1_q, sel1_d, sel2_q, sel2_d;
    logic       locked1_q, locked1_d, locked2_q, locked2_d;

    // Move presses first (priority ROCK > PAPER > SCISSORS, last press wins),
    // then the lock press is judged against the updated selection. A locked
    // player ignores everything. Returns {locked, sel}.
    function automatic logic [2:0] apply_presses(input logic [1:0] sel,
                                                 input logic       locked,
                                                 input logic [3:0] press);
        logic [1:0] s;
        logic       l;
        s = sel;
        l = locked;
        if (!locked) begin
            if (press[0])      s = SEL_ROCK;
            else if (press[1]) s = SEL_PAPER;
            else if (press[2]) s = SEL_SCISSORS;
            if (press[3] && (s != SEL_NONE)) l = 1'b1;
        end
        return {l, s};
    endfunction

    // Debouncer: a level flips only after the synchronised input disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        deb_d = deb_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Round FSM and per-player selection state.
    always_comb begin
        state_d   = state_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        locked1_d = locked1_q;
        locked2_d = locked2_q;
        case (state_q)
            COLLECT: begin
                {locked1_d, sel1_d} = apply_presses(sel1_q, locked1_q, press_q[3:0]);
                {locked2_d, sel2_d} = apply_presses(sel2_q, locked2_q, press_q[7:4]);
                if (locked1_q && locked2_q) state_d = REVEAL;
            end
            REVEAL: begin
                if (round_ready) begin
                    sel1_d    = SEL_NONE;
                    sel2_d    = SEL_NONE;
                    locked1_d = 1'b0;
                    locked2_d = 1'b0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for every button to be let go so a button still held
                // at acceptance cannot leak into the next round.
                if (deb_q == '0) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs before any of them update.
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            // NOTE: the counter array is only eight small registers, so it is
            // reset like any other flop rather than treated as a memory.
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            state_q    <= COLLECT;
            sel1_q     <= SEL_NONE;
            sel2_q     <= SEL_NONE;
            locked1_q  <= 1'b0;
            locked2_q  <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            // Registered rising-edge detect of the debounced level.
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            locked1_q  <= locked1_d;
            locked2_q  <= locked2_d;
        end
    end

    // Moves are decoded only in REVEAL so selections stay secret otherwise;
    // sel is frozen in REVEAL, so the decode is stable until acceptance.
    assign round_valid = (state_q == REVEAL);
    assign rock1       = round_valid && (sel1_q == SEL_ROCK);
    assign paper1      = round_valid && (sel1_q == SEL_PAPER);
    assign scissors1   = round_valid && (sel1_q == SEL_SCISSORS);
    assign rock2       = round_valid && (sel2_q == SEL_ROCK);
    assign paper2      = round_valid && (sel2_q == SEL_PAPER);
    assign scissors2   = round_valid && (sel2_q == SEL_SCISSORS);
    assign locked1     = locked1_q;
    assign locked2     = locked2_q;

endmodule

// File: tb/tb_rps_move_capture.sv
// ---------------------------------------------------------------------------
// tb_rps_move_capture
//
// Self-checking bench for rps_move_capture. Stimulus works at the level of
// clean button presses (held well beyond the debounce time, then released).
// A press-level model of the game rules predicts lock status and the
// revealed moves; predicted rounds are queued and a monitor compares them
// whenever the DUT hands a round over.
// ---------------------------------------------------------------------------
module tb_rps_move_capture;

    localparam int D    = 16;
    localparam int HOLD = D + 6;

    logic clk, rst;
    logic btn_rock1, btn_paper1, btn_scissors1, btn_lock1;
    logic btn_rock2, btn_paper2, btn_scissors2, btn_lock2;
    logic round_ready;
    logic rock1, paper1, scissors1, rock2, paper2, scissors2;
    logic round_valid, locked1, locked2;

    rps_move_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .btn_rock1(btn_rock1), .btn_paper1(btn_paper1),
        .btn_scissors1(btn_scissors1), .btn_lock1(btn_lock1),
        .btn_rock2(btn_rock2), .btn_paper2(btn_paper2),
        .btn_scissors2(btn_scissors2), .btn_lock2(btn_lock2),
        .round_ready(round_ready),
        .rock1(rock1), .paper1(paper1), .scissors1(scissors1),
        .rock2(rock2), .paper2(paper2), .scissors2(scissors2),
        .round_valid(round_valid), .locked1(locked1), .locked2(locked2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [5:0] moves;
    assign moves = {rock1, paper1, scissors1, rock2, paper2, scissors2};

    // Expected revealed rounds, {rock1,paper1,scissors1,rock2,paper2,scissors2}.
    logic [5:0] exp_q[$];

    // Press-level game model: sel 0 none, 1 rock, 2 paper, 3 scissors.
    int m_sel[2];
    bit m_lock[2];
    bit pushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mask per player nibble: bit0 rock, bit1 paper, bit2 scissors, bit3 lock.
    task automatic drive(input logic [7:0] mask);
        {btn_lock2, btn_scissors2, btn_paper2, btn_rock2,
         btn_lock1, btn_scissors1, btn_paper1, btn_rock1} = mask;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] model_moves();
        logic [5:0] r;
        r = '0;
        r[5] = (m_sel[0] == 1); r[4] = (m_sel[0] == 2); r[3] = (m_sel[0] == 3);
        r[2] = (m_sel[1] == 1); r[1] = (m_sel[1] == 2); r[0] = (m_sel[1] == 3);
        return r;
    endfunction

    task automatic model_clear();
        m_sel[0] = 0; m_sel[1] = 0;
        m_lock[0] = 0; m_lock[1] = 0;
        pushed = 0;
    endtask

    task automatic model_press(input logic [7:0] mask);
        for (int p = 0; p < 2; p++) begin
            logic [3:0] b;
            b = mask[p*4 +: 4];
            if (!m_lock[p]) begin
                if (b[0])      m_sel[p] = 1;
                else if (b[1]) m_sel[p] = 2;
                else if (b[2]) m_sel[p] = 3;
                if (b[3] && m_sel[p] != 0) m_lock[p] = 1;
            end
        end
        if (!pushed && m_lock[0] && m_lock[1]) begin
            exp_q.push_back(model_moves());
            pushed = 1;
        end
    endtask

    task automatic do_press(input logic [7:0] mask);
        drive(mask);
        step(HOLD);
        drive(8'h00);
        step(HOLD);
        model_press(mask);
        check("locked1", locked1, m_lock[0]);
        check("locked2", locked2, m_lock[1]);
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!round_valid && n < 50) begin
            step(1);
            n++;
        end
        ok = round_valid;
        check("reveal_timeout", round_valid, 1'b1);
    endtask

    task automatic accept_round(input int hold);
        bit ok;
        wait_valid(ok);
        if (!ok) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            model_clear();
            return;
        end
        repeat (hold) begin
            step(1);
            check("valid_held", round_valid, 1'b1);
        end
        round_ready = 1'b1;
        step(1);
        round_ready = 1'b0;
        check("valid_cleared", round_valid, 1'b0);
        check("locks_cleared", {locked1, locked2}, 2'b00);
        check("moves_cleared", moves, 6'b0);
        model_clear();
    endtask

    // Monitor: compares each handed-over round against the queue, and checks
    // that no move leaks while round_valid is low.
    always @(negedge clk) begin
        if (!rst) begin
            if (round_valid && round_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_round: got moves 0x%0h, no round expected", moves);
                end else begin
                    check("round_moves", moves, exp_q.pop_front());
                end
            end
            if (!round_valid) check("secret", moves, 6'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int seen;
        logic [7:0] mask;

        model_clear();
        drive(8'h00);
        round_ready = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("reset_outputs", {moves, round_valid, locked1, locked2}, 9'b0);
        seen = 0;
        repeat (100) begin
            step(1);
            if (round_valid) seen++;
        end
        check("no_valid_after_reset", seen, 0);

        // Glitches shorter than the debounce time must never register.
        for (int k = 0; k < 5; k++) begin
            drive(8'h01); step(5);
            drive(8'h00); step(5);
        end
        step(HOLD);
        do_press(8'h08);          // lock with no selection: ignored

        // Exact latency: rock1+lock1 first sampled at edge 0 -> locked at D+3.
        drive(8'h09);
        step(D + 3);              // now just past edge D+2
        check("latency_early", locked1, 1'b0);
        step(1);                  // just past edge D+3
        check("latency_edge", locked1, 1'b1);
        drive(8'h00);
        step(HOLD);
        model_press(8'h09);
        do_press(8'h90);          // P2 rock + lock in one press
        accept_round(1);

        // Full round, last press wins, held 20 cycles without ready.
        do_press(8'h02);
        do_press(8'h04);
        do_press(8'h08);
        do_press(8'h10);
        do_press(8'h80);
        accept_round(20);

        // Lock rules.
        do_press(8'h08);
        do_press(8'h01);
        do_press(8'h08);
        do_press(8'h02);          // ignored, P1 already locked
        do_press(8'h20);
        do_press(8'h84);          // P2 locks, P1 scissors ignored
        accept_round(3);

        // Simultaneous presses and a button held across acceptance.
        do_press(8'h50);          // P2 rock+scissors -> rock
        do_press(8'h01);
        do_press(8'h08);
        do_press(8'h80);
        wait_valid(ok);
        drive(8'h02);             // hold paper1 through REVEAL and acceptance
        step(HOLD);
        accept_round(2);
        drive(8'h92);             // P2 rock+lock while paper1 still held
        step(HOLD);
        drive(8'h02);
        step(HOLD);
        check("release_ignores_presses", locked2, 1'b0);
        drive(8'h00);
        step(HOLD);
        do_press(8'h08);          // no selection leaked from the held paper
        do_press(8'h0A);          // paper pressed again with lock
        do_press(8'hC0);          // P2 scissors + lock
        accept_round(0);

        // Reset in the middle of REVEAL drops the round.
        do_press(8'h99);
        wait_valid(ok);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_reveal_valid", round_valid, 1'b0);
        check("rst_reveal_locks", {locked1, locked2}, 2'b00);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        model_clear();
        do_press(8'h22);
        do_press(8'h88);
        accept_round(4);

        // Randomised rounds.
        for (int r = 0; r < 10; r++) begin
            int n;
            n = 0;
            if ($urandom_range(0, 1) == 1) begin
                round_ready = 1'b1;  // ready while not valid has no effect
                step(2);
                round_ready = 1'b0;
                check("ready_not_valid", round_valid, 1'b0);
            end
            while (!(m_lock[0] && m_lock[1]) && n < 10) begin
                mask = 8'($urandom_range(0, 255));
                do_press(mask);
                n++;
            end
            if (!(m_lock[0] && m_lock[1])) do_press(8'h99);
            if ($urandom_range(0, 2) == 0) begin
                wait_valid(ok);
                do_press(8'($urandom_range(0, 255)));  // ignored in REVEAL
                check("reveal_presses_ignored", round_valid, 1'b1);
            end
            accept_round($urandom_range(0, 5));
        end

        step(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
